// File: rtl/serial_imem_link.sv
`default_nettype none
//==============================================================================
// Module   : serial_imem_link
// Purpose  : Serial-address to parallel-memory to serial-data fetch bridge.
//            Optional even-parity trailer bit: define SERIAL_LINK_PARITY_EN.
// Revision : 1.0 - initial release
//==============================================================================
module serial_imem_link #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 16,
   parameter int MEM_DEPTH = 1024
) (
   input  logic              sys_clk,
   input  logic              sys_reset,
   input  logic              addr_bit_in,
   input  logic              addr_bit_valid,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              data_bit_out,
   output logic              data_bit_valid,
   output logic              done,
   output logic              busy,
   output logic [1:0]        err
);

`ifdef SERIAL_LINK_PARITY_EN
   localparam int TX_BITS = DATA_W + 1;
`else
   localparam int TX_BITS = DATA_W;
`endif
   localparam int CNT_MAX = (ADDR_W > TX_BITS) ? ADDR_W : TX_BITS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_BITS);
   localparam logic [CNT_W-1:0] TX_PENULT = CNT_W'(TX_BITS - 1);
   localparam logic [31:0]      DEPTH_U   = 32'(MEM_DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RX_ADDR  = 2'd1,
      MEM_WAIT = 2'd2,
      TX_DATA  = 2'd3
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] shift_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              dbit_q;
   logic              dvalid_q;
   logic              done_q;
   logic [1:0]        err_q;
`ifdef SERIAL_LINK_PARITY_EN
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
   logic              parity_q;
`endif

   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] tx_word_d;
   logic              rx_state_d;
   logic              addr_last_d;
   logic              addr_oob_d;
   logic              tx_start_d;

   always_comb begin
      addr_d      = ADDR_W'({addr_q, addr_bit_in});
      addr_oob_d  = (32'(addr_d) >= DEPTH_U);
      addr_last_d = (state_q == IDLE) ? (ADDR_W == 1) : (cnt_q == ADDR_LAST);
      rx_state_d  = (state_q == IDLE) || (state_q == RX_ADDR);
      // Out-of-range fetches transmit an all-zero word instead of memory data.
      tx_word_d   = (state_q == MEM_WAIT) ? mem_rdata : '0;
      tx_start_d  = ((state_q == MEM_WAIT) && mem_ack) ||
                    (rx_state_d && addr_bit_valid && addr_last_d && addr_oob_d);
   end

   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         shift_q    <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         dbit_q     <= 1'b0;
         dvalid_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 2'b00;
`ifdef SERIAL_LINK_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, RX_ADDR: begin
               if (addr_bit_valid) begin
                  addr_q <= addr_d;
                  cnt_q  <= (state_q == IDLE) ? CNT_ONE : cnt_q + CNT_ONE;
                  if (!addr_last_d) begin
                     state_q <= RX_ADDR;
                  end else if (addr_oob_d) begin
                     err_q[1] <= 1'b1;
                  end else begin
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= addr_d;
                     state_q    <= MEM_WAIT;
                  end
               end
            end
            MEM_WAIT: begin
               if (addr_bit_valid) err_q[0] <= 1'b1;
               if (mem_ack) mem_req_q <= 1'b0;
            end
            TX_DATA: begin
               if (addr_bit_valid) err_q[0] <= 1'b1;
               if (cnt_q == TX_LAST) begin
                  dvalid_q <= 1'b0;
                  dbit_q   <= 1'b0;
                  state_q  <= IDLE;
               end else begin
`ifdef SERIAL_LINK_PARITY_EN
                  dbit_q <= (cnt_q == DATA_LAST) ? parity_q : shift_q[DATA_W-1];
`else
                  dbit_q <= shift_q[DATA_W-1];
`endif
                  shift_q <= shift_q << 1;
                  cnt_q   <= cnt_q + CNT_ONE;
                  done_q  <= (cnt_q == TX_PENULT);
               end
            end
            default: state_q <= IDLE;
         endcase

         // The first data bit goes out on the cycle right after the load.
         if (tx_start_d) begin
            dbit_q   <= tx_word_d[DATA_W-1];
            shift_q  <= tx_word_d << 1;
            cnt_q    <= CNT_ONE;
            dvalid_q <= 1'b1;
            done_q   <= (TX_BITS == 1);
            state_q  <= TX_DATA;
`ifdef SERIAL_LINK_PARITY_EN
            parity_q <= ^tx_word_d;
`endif
         end
      end
   end

   assign mem_req        = mem_req_q;
   assign mem_addr       = mem_addr_q;
   assign data_bit_out   = dbit_q;
   assign data_bit_valid = dvalid_q;
   assign done           = done_q;
   assign busy           = (state_q != IDLE);
   assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_imem_link.sv
`default_nettype none
//==============================================================================
// Module   : tb_serial_imem_link
// Purpose  : Randomised self-checking bench; instance A uses MEM_DEPTH=1024,
//            instance B uses MEM_DEPTH=512. Honours SERIAL_LINK_PARITY_EN.
// Revision : 1.0 - initial release
//==============================================================================
module tb_serial_imem_link;
   localparam int AW = 10;
   localparam int DW = 16;
`ifdef SERIAL_LINK_PARITY_EN
   localparam int TXB = DW + 1;
`else
   localparam int TXB = DW;
`endif

   logic          sys_clk        = 1'b0;
   logic          sys_reset      = 1'b0;
   logic          addr_bit_in    = 1'b0;
   logic          addr_bit_valid = 1'b0;
   logic          mem_ack        = 1'b0;
   logic [DW-1:0] mem_rdata      = '0;
   logic          sel            = 1'b0;

   logic va, vb;
   logic req_a, req_b, dbit_a, dbit_b, dv_a, dv_b, done_a, done_b, busy_a, busy_b;
   logic [AW-1:0] maddr_a, maddr_b;
   logic [1:0]    err_a, err_b;
   logic obs_req, obs_dbit, obs_dv, obs_done, obs_busy;
   logic [AW-1:0] obs_maddr;
   logic [1:0]    obs_err;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [1:0] exp_err [2];

   assign va = addr_bit_valid & ~sel;
   assign vb = addr_bit_valid & sel;
   assign obs_req   = sel ? req_b   : req_a;
   assign obs_maddr = sel ? maddr_b : maddr_a;
   assign obs_dbit  = sel ? dbit_b  : dbit_a;
   assign obs_dv    = sel ? dv_b    : dv_a;
   assign obs_done  = sel ? done_b  : done_a;
   assign obs_busy  = sel ? busy_b  : busy_a;
   assign obs_err   = sel ? err_b   : err_a;

   always #5 sys_clk = ~sys_clk;

   serial_imem_link #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1024)) u_dut_a (
      .sys_clk(sys_clk), .sys_reset(sys_reset),
      .addr_bit_in(addr_bit_in), .addr_bit_valid(va),
      .mem_req(req_a), .mem_addr(maddr_a), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .data_bit_out(dbit_a), .data_bit_valid(dv_a), .done(done_a), .busy(busy_a), .err(err_a)
   );

   serial_imem_link #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(512)) u_dut_b (
      .sys_clk(sys_clk), .sys_reset(sys_reset),
      .addr_bit_in(addr_bit_in), .addr_bit_valid(vb),
      .mem_req(req_b), .mem_addr(maddr_b), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .data_bit_out(dbit_b), .data_bit_valid(dv_b), .done(done_b), .busy(busy_b), .err(err_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected serial stream: word MSB first, plus even parity when enabled.
   function automatic logic [31:0] model_bits(input logic [DW-1:0] word);
      logic [31:0] b;
      b = 32'(word);
      if (TXB > DW) b = (b << 1) | 32'(^word);
      return b;
   endfunction

   // Called at a falling edge; returns at the falling edge after the DUT is idle again.
   task automatic fetch(input logic [AW-1:0] addr, input int depth, input int gap_pos,
                        input int gap_len, input logic [DW-1:0] word, input int ack_dly,
                        input bit toggle);
      bit          oob;
      logic [31:0] exp_bits;
      logic [31:0] got_bits;
      int          n, ndone, done_at;
      oob      = (int'(addr) >= depth);
      exp_bits = model_bits(oob ? '0 : word);
      for (int i = AW-1; i >= 0; i--) begin
         if ((AW-1-i) == gap_pos) begin
            repeat (gap_len) begin
               addr_bit_valid = 1'b0;
               addr_bit_in    = 1'($urandom);
               @(negedge sys_clk);
            end
            check_eq("gap_busy", 32'(obs_busy), 32'd1);
            check_eq("gap_noreq", 32'(obs_req), 32'd0);
         end
         addr_bit_valid = 1'b1;
         addr_bit_in    = addr[i];
         @(negedge sys_clk);
      end
      addr_bit_valid = 1'b0;
      if (!oob) begin
         check_eq("req_up", 32'(obs_req), 32'd1);
         check_eq("req_addr", 32'(obs_maddr), 32'(addr));
         for (int d = 0; d < ack_dly; d++) begin
            @(negedge sys_clk);
            check_eq("req_hold", 32'({obs_req, obs_maddr}), 32'({1'b1, addr}));
         end
         mem_ack   = 1'b1;
         mem_rdata = word;
         @(negedge sys_clk);
         mem_ack   = 1'b0;
         mem_rdata = DW'($urandom);
         check_eq("req_drop", 32'(obs_req), 32'd0);
      end else begin
         exp_err[sel][1] = 1'b1;
         check_eq("oob_noreq", 32'(obs_req), 32'd0);
      end
      check_eq("first_bit_latency", 32'(obs_dv), 32'd1);
      got_bits = '0;
      n = 0; ndone = 0; done_at = 0;
      for (int c = 0; c < 3*TXB; c++) begin
         if (obs_dv) begin
            got_bits = (got_bits << 1) | 32'(obs_dbit);
            n++;
         end
         if (obs_done) begin
            ndone++;
            done_at = n;
         end
         if (obs_done || (!obs_dv && n > 0)) break;
         if (toggle) begin
            addr_bit_valid = (c % 2 == 0) ? 1'b1 : 1'($urandom);
            addr_bit_in    = 1'($urandom);
            mem_ack        = 1'($urandom);
            if (addr_bit_valid) exp_err[sel][0] = 1'b1;
         end
         @(negedge sys_clk);
      end
      addr_bit_valid = 1'b0;
      mem_ack        = 1'b0;
      check_eq("nbits", 32'(n), 32'(TXB));
      check_eq("bits", got_bits, exp_bits);
      check_eq("ndone", 32'(ndone), 32'd1);
      check_eq("done_last", 32'(done_at), 32'(TXB));
      @(negedge sys_clk);
      check_eq("idle_after", 32'({obs_busy, obs_dv, obs_req, obs_done}), 32'd0);
      check_eq("err", 32'(obs_err), 32'(exp_err[sel]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt_dv, cnt_done, cnt_req, cnt_busy;
      exp_err[0] = 2'b00;
      exp_err[1] = 2'b00;
      repeat (3) @(negedge sys_clk);
      check_eq("rst_a", 32'({req_a, maddr_a, dbit_a, dv_a, done_a, busy_a, err_a}), 32'd0);
      check_eq("rst_b", 32'({req_b, maddr_b, dbit_b, dv_b, done_b, busy_b, err_b}), 32'd0);
      sys_reset = 1'b1;
      @(negedge sys_clk);

      sel = 1'b0;
      fetch(10'h005, 1024, -1, 0, 16'hA5C3, 2, 1'b0);
      fetch(10'h3FF, 1024, 4, 3, DW'($urandom), 0, 1'b0);
      sel = 1'b1;
      fetch(10'h200, 512, -1, 0, DW'($urandom), 1, 1'b0);
      sel = 1'b0;
      fetch(10'h0A7, 1024, -1, 0, 16'h5A3C, 1, 1'b1);
      fetch(10'h011, 1024, -1, 0, 16'h0001, 0, 1'b0);

      for (int k = 0; k < 8; k++) begin
         sel = 1'($urandom);
         fetch(AW'($urandom), sel ? 512 : 1024,
               (k % 2 == 1) ? int'($urandom_range(1, AW-1)) : -1,
               int'($urandom_range(1, 4)), DW'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom));
      end

      // Reset while waiting for memory, then a stale ack after release.
      sel = 1'b0;
      for (int i = AW-1; i >= 0; i--) begin
         addr_bit_valid = 1'b1;
         addr_bit_in    = 1'(i % 3);
         @(negedge sys_clk);
      end
      addr_bit_valid = 1'b0;
      check_eq("rst_pre_memwait", 32'(obs_req), 32'd1);
      @(negedge sys_clk);
      sys_reset = 1'b0;
      #1;
      check_eq("rst_mid_a", 32'({req_a, maddr_a, dbit_a, dv_a, done_a, busy_a, err_a}), 32'd0);
      check_eq("rst_mid_b", 32'({req_b, maddr_b, dbit_b, dv_b, done_b, busy_b, err_b}), 32'd0);
      exp_err[0] = 2'b00;
      exp_err[1] = 2'b00;
      @(negedge sys_clk);
      sys_reset = 1'b1;
      @(negedge sys_clk);
      mem_ack   = 1'b1;
      mem_rdata = 16'hFFFF;
      @(negedge sys_clk);
      mem_ack = 1'b0;
      cnt_dv = 0; cnt_done = 0; cnt_req = 0; cnt_busy = 0;
      repeat (20) begin
         @(negedge sys_clk);
         cnt_dv   += int'(dv_a);
         cnt_done += int'(done_a);
         cnt_req  += int'(req_a);
         cnt_busy += int'(busy_a);
      end
      check_eq("late_ack_dv", 32'(cnt_dv), 32'd0);
      check_eq("late_ack_done", 32'(cnt_done), 32'd0);
      check_eq("late_ack_req", 32'(cnt_req), 32'd0);
      check_eq("late_ack_busy", 32'(cnt_busy), 32'd0);
      check_eq("late_ack_err", 32'(err_a), 32'(exp_err[0]));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
